// File: rtl/sysreg_pkg.sv
// Shared constants for the system register read side: window offsets,
// control bit positions, shadow layout and shadow reset values.
package sysreg_pkg;

  localparam logic [6:0] SR_SQ1_LO      = 7'h20;
  localparam logic [6:0] SR_SQ1_HI      = 7'h21;
  localparam logic [6:0] SR_SQ2_LO      = 7'h22;
  localparam logic [6:0] SR_SQ2_HI      = 7'h23;
  localparam logic [6:0] SR_PWM         = 7'h24;
  localparam logic [6:0] SR_AUD_CTRL    = 7'h26;
  localparam logic [6:0] SR_VOL_FIRST   = 7'h27;
  localparam logic [6:0] SR_VOL_LAST    = 7'h2F;
  localparam logic [6:0] SR_T0_RELOAD   = 7'h30;
  localparam logic [6:0] SR_T0_CTRL     = 7'h31;
  localparam logic [6:0] SR_T1_CTRL     = 7'h33;
  localparam logic [6:0] SR_T1_RSVD     = 7'h34;
  localparam logic [6:0] SR_T1_RELOAD   = 7'h35;
  localparam logic [6:0] SR_TMR_STAT    = 7'h36;
  localparam logic [6:0] SR_T1_CTRL_M   = 7'h38;
  localparam logic [6:0] SR_T1_RSVD_M   = 7'h39;
  localparam logic [6:0] SR_T1_RELOAD_M = 7'h3A;

  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int NUM_VOL        = 9;

  localparam logic [11:0] SQ_FREQ_RST  = 12'h000;
  localparam logic [7:0]  AUD_CTRL_RST = 8'h00;
  localparam logic [3:0]  VOL_RST      = 4'h0;
  localparam logic [7:0]  T_RELOAD_RST = 8'h00;
  localparam logic [1:0]  T_CTRL_RST   = 2'b00;

  typedef struct packed {
    logic [11:0]               sq1;
    logic [11:0]               sq2;
    logic [7:0]                aud_ctrl;
    logic [NUM_VOL-1:0][3:0]   vol;
    logic [7:0]                t0_reload;
    logic [1:0]                t0_ctrl;
  } shadow_t;

  localparam shadow_t SHADOW_RST = '{
    sq1:       SQ_FREQ_RST,
    sq2:       SQ_FREQ_RST,
    aud_ctrl:  AUD_CTRL_RST,
    vol:       {NUM_VOL{VOL_RST}},
    t0_reload: T_RELOAD_RST,
    t0_ctrl:   T_CTRL_RST
  };

  function automatic logic is_vol(input logic [6:0] ab);
    return (ab >= SR_VOL_FIRST) && (ab <= SR_VOL_LAST);
  endfunction

  // 0x27..0x2F map onto volume slots 0..8 via the low nibble.
  function automatic logic [3:0] vol_index(input logic [6:0] ab);
    return ab[3:0] - 4'h7;
  endfunction

  // A reload of 0 starts the count at 255 so the period becomes 256.
  function automatic logic [7:0] timer_start(input logic [7:0] reload);
    return (reload == 8'h00) ? 8'hFF : reload;
  endfunction

endpackage

// File: rtl/sys_timer.sv
// 8-bit down-counter with auto-reload and a sticky expiry flag.
// Expiry (set) has priority over a clear-on-read in the same cycle.
module sys_timer
  import sysreg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       load,
  input  logic [7:0] reload,
  input  logic       run,
  input  logic       clr,
  output logic       flag
);

  logic [7:0] cnt_q, cnt_d;
  logic       flag_q, flag_d;
  logic       expire;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    expire = 1'b0;
    if (ce) begin
      if (load) begin
        cnt_d = timer_start(reload);
      end else if (run) begin
        if (cnt_q == 8'h00) begin
          cnt_d  = timer_start(reload);
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    end
    if (clr) begin
      flag_d = 1'b0;
    end
    if (expire) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= 8'h00;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/sysreg_read.sv
// Read side of the system register window 0x20-0x3F: shadows, PWM counter,
// timer 0 and its irq. Define SYSREG_TIMER1_EN to add the second timer.
module sysreg_read
  import sysreg_pkg::*;
#(
  parameter logic [7:0] OPEN_BUS = 8'hFF
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       sys_cs,
  input  logic       cpu_rwn,
  input  logic [6:0] AB,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic       irq_n
);

  // Read response: dout_oe is the valid for dout, raised on the edge that
  // samples a read access; there is no ready, the CPU always takes the data.
  logic rd_acc, wr_acc;
  assign rd_acc = ce & sys_cs & cpu_rwn;
  assign wr_acc = ce & sys_cs & ~cpu_rwn;

  shadow_t    shadow_q, shadow_d;
  logic [7:0] pwm_q, pwm_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_oe_q, dout_oe_d;
  logic [7:0] rdata;

  logic       t0_load, t0_clr, t0_flag;
  logic [7:0] t0_reload_in;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_acc) begin
      if (is_vol(AB)) begin
        shadow_d.vol[vol_index(AB)] = din[3:0];
      end else begin
        case (AB)
          SR_SQ1_LO:    shadow_d.sq1[7:0]  = din;
          SR_SQ1_HI:    shadow_d.sq1[11:8] = din[3:0];
          SR_SQ2_LO:    shadow_d.sq2[7:0]  = din;
          SR_SQ2_HI:    shadow_d.sq2[11:8] = din[3:0];
          SR_AUD_CTRL:  shadow_d.aud_ctrl  = din;
          SR_T0_RELOAD: shadow_d.t0_reload = din;
          SR_T0_CTRL:   shadow_d.t0_ctrl   = din[1:0];
          default:      shadow_d = shadow_q;
        endcase
      end
    end
  end

  always_comb begin
    pwm_d = ce ? pwm_q + 8'd1 : pwm_q;
  end

  // The counter loads from din directly so a reload write takes effect at once.
  always_comb begin
    t0_load      = wr_acc && (AB == SR_T0_RELOAD);
    t0_reload_in = t0_load ? din : shadow_q.t0_reload;
  end

  sys_timer u_timer0 (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .load   (t0_load),
    .reload (t0_reload_in),
    .run    (shadow_q.t0_ctrl[CTRL_RUN_BIT]),
    .clr    (t0_clr),
    .flag   (t0_flag)
  );

`ifdef SYSREG_TIMER1_EN
  logic [7:0] t1_reload_q, t1_reload_d;
  logic [1:0] t1_ctrl_q, t1_ctrl_d;
  logic       t1_load, t1_clr, t1_flag;
  logic [7:0] t1_reload_in;

  always_comb begin
    t1_reload_d = t1_reload_q;
    t1_ctrl_d   = t1_ctrl_q;
    if (wr_acc) begin
      case (AB)
        SR_T1_CTRL, SR_T1_CTRL_M:     t1_ctrl_d   = din[1:0];
        SR_T1_RELOAD, SR_T1_RELOAD_M: t1_reload_d = din;
        default: begin
          t1_reload_d = t1_reload_q;
          t1_ctrl_d   = t1_ctrl_q;
        end
      endcase
    end
  end

  always_comb begin
    t1_load      = wr_acc && ((AB == SR_T1_RELOAD) || (AB == SR_T1_RELOAD_M));
    t1_reload_in = t1_load ? din : t1_reload_q;
    t1_clr       = rd_acc && (AB == SR_TMR_STAT);
    t0_clr       = rd_acc && ((AB == SR_T0_CTRL) || (AB == SR_TMR_STAT));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      t1_reload_q <= T_RELOAD_RST;
      t1_ctrl_q   <= T_CTRL_RST;
    end else begin
      t1_reload_q <= t1_reload_d;
      t1_ctrl_q   <= t1_ctrl_d;
    end
  end

  sys_timer u_timer1 (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .load   (t1_load),
    .reload (t1_reload_in),
    .run    (t1_ctrl_q[CTRL_RUN_BIT]),
    .clr    (t1_clr),
    .flag   (t1_flag)
  );

  assign irq_n = ~((t0_flag & shadow_q.t0_ctrl[CTRL_IRQEN_BIT]) |
                   (t1_flag & t1_ctrl_q[CTRL_IRQEN_BIT]));
`else
  always_comb begin
    t0_clr = rd_acc && (AB == SR_T0_CTRL);
  end

  assign irq_n = ~(t0_flag & shadow_q.t0_ctrl[CTRL_IRQEN_BIT]);
`endif

  always_comb begin
    rdata = OPEN_BUS;
    if (is_vol(AB)) begin
      rdata = {4'h0, shadow_q.vol[vol_index(AB)]};
    end else begin
      case (AB)
        SR_SQ1_LO:    rdata = shadow_q.sq1[7:0];
        SR_SQ1_HI:    rdata = {4'h0, shadow_q.sq1[11:8]};
        SR_SQ2_LO:    rdata = shadow_q.sq2[7:0];
        SR_SQ2_HI:    rdata = {4'h0, shadow_q.sq2[11:8]};
        SR_PWM:       rdata = pwm_q;
        SR_AUD_CTRL:  rdata = shadow_q.aud_ctrl;
        SR_T0_RELOAD: rdata = shadow_q.t0_reload;
        SR_T0_CTRL:   rdata = {t0_flag, 5'b00000, shadow_q.t0_ctrl};
`ifdef SYSREG_TIMER1_EN
        SR_T1_CTRL, SR_T1_CTRL_M:     rdata = {6'b000000, t1_ctrl_q};
        SR_T1_RSVD, SR_T1_RSVD_M:     rdata = 8'h00;
        SR_T1_RELOAD, SR_T1_RELOAD_M: rdata = t1_reload_q;
        SR_TMR_STAT:                  rdata = {t1_flag, t0_flag, 6'b000000};
`endif
        default:      rdata = OPEN_BUS;
      endcase
    end
  end

  // dout holds across non-read cycles; only dout_oe reacts to them.
  always_comb begin
    dout_d    = dout_q;
    dout_oe_d = dout_oe_q;
    if (ce) begin
      if (rd_acc) begin
        dout_d    = rdata;
        dout_oe_d = 1'b1;
      end else begin
        dout_oe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q  <= SHADOW_RST;
      pwm_q     <= 8'h00;
      dout_q    <= OPEN_BUS;
      dout_oe_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      pwm_q     <= pwm_d;
      dout_q    <= dout_d;
      dout_oe_q <= dout_oe_d;
    end
  end

  assign dout    = dout_q;
  assign dout_oe = dout_oe_q;

endmodule

// File: tb/tb_sysreg_read.sv
// Bench for sysreg_read: directed scenarios plus random traffic, checked
// against a period-based register/timer model through an expected-data queue.
module tb_sysreg_read;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic       sys_cs;
  logic       cpu_rwn;
  logic [6:0] AB;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_oe;
  logic       irq_n;

  always #5 clk = ~clk;

  sysreg_read #(.OPEN_BUS(8'hFF)) dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .sys_cs  (sys_cs),
    .cpu_rwn (cpu_rwn),
    .AB      (AB),
    .din     (din),
    .dout    (dout),
    .dout_oe (dout_oe),
    .irq_n   (irq_n)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  // Reference model state
  logic [11:0] m_sq1, m_sq2;
  logic [7:0]  m_aud;
  logic [3:0]  m_vol[9];
  logic [7:0]  m_rel[2];
  logic        m_run[2], m_ie[2], m_flag[2];
  int          m_left[2];
  logic [7:0]  m_pwm;
  logic        m_irq_n;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int period(input logic [7:0] r);
    return (r == 8'h00) ? 256 : int'(r) + 1;
  endfunction

  task automatic model_reset();
    m_sq1 = '0; m_sq2 = '0; m_aud = '0; m_pwm = '0; m_irq_n = 1'b1;
    for (int i = 0; i < 9; i++) m_vol[i] = '0;
    for (int t = 0; t < 2; t++) begin
      m_rel[t] = '0; m_run[t] = 1'b0; m_ie[t] = 1'b0; m_flag[t] = 1'b0;
      m_left[t] = 1;
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] ab);
    int idx;
    idx = int'(ab) - 'h27;
    if (idx >= 0 && idx < 9) return {4'h0, m_vol[idx]};
    case (ab)
      7'h20: return m_sq1[7:0];
      7'h21: return {4'h0, m_sq1[11:8]};
      7'h22: return m_sq2[7:0];
      7'h23: return {4'h0, m_sq2[11:8]};
      7'h24: return m_pwm;
      7'h26: return m_aud;
      7'h30: return m_rel[0];
      7'h31: return {m_flag[0], 5'b00000, m_ie[0], m_run[0]};
`ifdef SYSREG_TIMER1_EN
      7'h33, 7'h38: return {6'b000000, m_ie[1], m_run[1]};
      7'h34, 7'h39: return 8'h00;
      7'h35, 7'h3A: return m_rel[1];
      7'h36: return {m_flag[1], m_flag[0], 6'b000000};
`endif
      default: return 8'hFF;
    endcase
  endfunction

  task automatic model_write(input logic [6:0] ab, input logic [7:0] d);
    int idx;
    idx = int'(ab) - 'h27;
    if (idx >= 0 && idx < 9) begin
      m_vol[idx] = d[3:0];
      return;
    end
    case (ab)
      7'h20: m_sq1[7:0]  = d;
      7'h21: m_sq1[11:8] = d[3:0];
      7'h22: m_sq2[7:0]  = d;
      7'h23: m_sq2[11:8] = d[3:0];
      7'h26: m_aud       = d;
      7'h30: m_rel[0]    = d;
      7'h31: begin m_run[0] = d[0]; m_ie[0] = d[1]; end
`ifdef SYSREG_TIMER1_EN
      7'h33, 7'h38: begin m_run[1] = d[0]; m_ie[1] = d[1]; end
      7'h35, 7'h3A: m_rel[1] = d;
`endif
      default: ;
    endcase
  endtask

  // One CPU cycle of the model: read sees pre-edge state, clear-on-read
  // precedes the timer tick so an expiry in the same cycle survives.
  task automatic model_step(input logic c, input logic cs, input logic rwn,
                            input logic [6:0] ab, input logic [7:0] d);
    logic rd, wr;
    logic ld[2];
    if (!c) return;
    rd = cs & rwn;
    wr = cs & ~rwn;
    if (rd) exp_q.push_back(model_read(ab));
    if (rd && ab == 7'h31) m_flag[0] = 1'b0;
`ifdef SYSREG_TIMER1_EN
    if (rd && ab == 7'h36) begin m_flag[0] = 1'b0; m_flag[1] = 1'b0; end
`endif
    m_pwm = m_pwm + 8'd1;
    ld[0] = wr && (ab == 7'h30);
    ld[1] = 1'b0;
`ifdef SYSREG_TIMER1_EN
    ld[1] = wr && (ab == 7'h35 || ab == 7'h3A);
`endif
    for (int t = 0; t < 2; t++) begin
      if (ld[t]) begin
        m_left[t] = period(d);
      end else if (m_run[t]) begin
        m_left[t] = m_left[t] - 1;
        if (m_left[t] == 0) begin
          m_flag[t] = 1'b1;
          m_left[t] = period(m_rel[t]);
        end
      end
    end
    if (wr) model_write(ab, d);
    m_irq_n = !((m_flag[0] && m_ie[0]) || (m_flag[1] && m_ie[1]));
  endtask

  // Driver tasks: inputs change on the falling edge only.
  task automatic drive(input logic c, input logic cs, input logic rwn,
                       input logic [6:0] ab, input logic [7:0] d);
    @(negedge clk);
    ce = c; sys_cs = cs; cpu_rwn = rwn; AB = ab; din = d;
    model_step(c, cs, rwn, ab, d);
  endtask

  task automatic wr(input logic [6:0] ab, input logic [7:0] d);
    drive(1'b1, 1'b1, 1'b0, ab, d);
  endtask

  task automatic rd(input logic [6:0] ab);
    drive(1'b1, 1'b1, 1'b1, ab, 8'h00);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b1, 7'h00, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; ce = 1'b1; sys_cs = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1; ce = 1'b0;
  endtask

  task automatic run_to_last_tick();
    int guard;
    guard = 0;
    while (m_left[0] != 1 && guard < 600) begin
      idle();
      guard++;
    end
    if (guard >= 600) begin
      n_cmp++; n_fail++;
      $display("FAIL timer_wait: no expiry within %0d cycles", guard);
    end
  endtask

  // Monitor: every edge, compare outputs; pop on each sampled read access.
  initial begin
    logic s_rst, s_ce, s_rd;
    logic [7:0] e_dout;
    logic e_oe;
    e_dout = 8'hFF;
    e_oe   = 1'b0;
    forever begin
      @(posedge clk);
      s_rst = reset;
      s_ce  = ce;
      s_rd  = ce & sys_cs & cpu_rwn;
      #1;
      if (!s_rst) begin
        e_dout = 8'hFF;
        e_oe   = 1'b0;
      end else if (s_rd) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rdata: read response with empty expected queue at %0t", $time);
        end else begin
          e_dout = exp_q.pop_front();
        end
        e_oe = 1'b1;
      end else if (s_ce) begin
        e_oe = 1'b0;
      end
      check("dout", dout, e_dout);
      check_bit("dout_oe", dout_oe, e_oe);
      check_bit("irq_n", irq_n, m_irq_n);
    end
  end

  initial begin
    logic c, cs, rwn;
    logic [6:0] ab;
    logic [7:0] d;

    reset = 1'b0; ce = 1'b0; sys_cs = 1'b0; cpu_rwn = 1'b1; AB = '0; din = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // shadow readback
    wr(7'h20, 8'h5A); wr(7'h21, 8'hF3); rd(7'h20); rd(7'h21);
    wr(7'h2F, 8'hC9); wr(7'h26, 8'hA5); rd(7'h2F); rd(7'h26);

    // PWM counts every ce since reset
    do_reset();
    repeat (10) idle();
    rd(7'h24);
    @(posedge clk); #1;
    check("pwm_after_10", dout, 8'd10);

    // timer 0: reload 4 fires 5 ce after run is set
    wr(7'h30, 8'h04); wr(7'h31, 8'h03);
    for (int i = 1; i <= 5; i++) begin
      idle();
      @(posedge clk); #1;
      check_bit("irq_t0_countdown", irq_n, (i == 5) ? 1'b0 : 1'b1);
    end
    rd(7'h31);
    @(posedge clk); #1;
    check("t0_ctrl_read", dout, 8'h83);
    check_bit("irq_n_after_clear", irq_n, 1'b1);

    // set/clear collision on the expiry cycle
    do_reset();
    wr(7'h30, 8'h02); wr(7'h31, 8'h03);
    run_to_last_tick();
    idle();
    run_to_last_tick();
    rd(7'h31);
    @(posedge clk); #1;
    check_bit("collision_bit7", dout[7], 1'b1);
    check_bit("collision_flag_kept", irq_n, 1'b0);
    rd(7'h31);

    // reload 0 gives a 256-ce period
    do_reset();
    wr(7'h30, 8'h00); wr(7'h31, 8'h03);
    repeat (255) idle();
    @(posedge clk); #1;
    check_bit("irq_reload0_255", irq_n, 1'b1);
    idle();
    @(posedge clk); #1;
    check_bit("irq_reload0_256", irq_n, 1'b0);

    // open bus
    rd(7'h25); rd(7'h3C); rd(7'h05); rd(7'h45); rd(7'h32); rd(7'h37);
`ifdef SYSREG_TIMER1_EN
    wr(7'h35, 8'h77);
`endif
    rd(7'h35);
    @(posedge clk); #1;
`ifdef SYSREG_TIMER1_EN
    check("t1_reload_read", dout, 8'h77);
`else
    check("open_bus_0x35", dout, 8'hFF);
`endif

    // reset while the irq is pending
    check_bit("irq_before_reset", irq_n, 1'b0);
    do_reset();
    check_bit("irq_after_reset", irq_n, 1'b1);
    check("dout_after_reset", dout, 8'hFF);
    check_bit("oe_after_reset", dout_oe, 1'b0);
    rd(7'h30);

`ifdef SYSREG_TIMER1_EN
    wr(7'h3A, 8'h02); wr(7'h38, 8'h03); wr(7'h31, 8'h01);
    repeat (6) idle();
    rd(7'h36); rd(7'h36); rd(7'h39); rd(7'h34); rd(7'h38); rd(7'h33);
`endif

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        c   = ($urandom_range(0, 4) != 0);
        cs  = ($urandom_range(0, 7) != 0);
        rwn = $urandom_range(0, 1) != 0;
        if ($urandom_range(0, 9) == 0) ab = 7'($urandom_range(0, 127));
        else ab = 7'(32'h20 + $urandom_range(0, 31));
        if (ab == 7'h30 || ab == 7'h35 || ab == 7'h3A) d = 8'($urandom_range(0, 5));
        else d = 8'($urandom);
        drive(c, cs, rwn, ab, d);
      end
    end

    repeat (3) drive(1'b0, 1'b0, 1'b1, 7'h00, 8'h00);
    @(posedge clk); #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: actual=%0d entries required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
